// File: rtl/wb_peripheral_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-peripheral-bus bridge.
package wb_peripheral_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_FINISH = 2'd3
    } bridge_state_e;

    // [23:12] picks the peripheral, [11:0] the register inside it
    localparam int PERIPHERAL_ADDRESS_WIDTH = 24;
    localparam int REGISTER_ADDRESS_WIDTH   = 12;

    // Returned on timeout (and on unclaimed reads when that check is built in)
    localparam logic [31:0] ERROR_READ_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_peripheral_bridge_timeout_counter.sv
// Counts consecutive busy cycles of one peripheral access; expired_o flags
// the last tolerated cycle so the FSM can terminate with an error.
module peripheral_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic incr_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over increment
    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (incr_i)
            count_d = count_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/wb_peripheral_bridge.sv
// Wishbone classic slave driving the shared peripheral register bus.
// Optional macro WB_PERIPHERAL_BRIDGE_NO_RESPONSE_ERROR_EN: reads that no
// peripheral claims (requestOutput low) end with err and all-ones data.
module wb_peripheral_bridge
    import wb_peripheral_bridge_pkg::*;
#(
    parameter logic [7:0] BASE_ADDRESS   = 8'h13,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] wb_data_o,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    output logic [PERIPHERAL_ADDRESS_WIDTH-1:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead,
    input  logic        peripheralBus_requestOutput,
    input  logic        peripheralBus_busy
);

    bridge_state_e state_q, state_d;
    logic          we_q, we_d, oe_q, oe_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    sel_q, sel_d;
    logic [PERIPHERAL_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic          cnt_clear, cnt_incr, cnt_expired;
    logic          select;
    logic          no_response;

    assign select = wb_cyc_i & wb_stb_i & (wb_adr_i[31:24] == BASE_ADDRESS);

`ifdef WB_PERIPHERAL_BRIDGE_NO_RESPONSE_ERROR_EN
    assign no_response = ~peripheralBus_requestOutput;
`else
    logic unused_request_output;
    assign unused_request_output = peripheralBus_requestOutput;
    assign no_response = 1'b0;
`endif

    peripheral_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .incr_i    (cnt_incr),
        .expired_o (cnt_expired)
    );

    // Next-state and registered-output decode; strobes/ack/err default low
    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        oe_d      = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (select) begin
                    addr_d  = wb_adr_i[PERIPHERAL_ADDRESS_WIDTH-1:0];
                    sel_d   = wb_sel_i;
                    wdata_d = wb_data_i;
                    we_d    = wb_we_i;
                    oe_d    = ~wb_we_i;
                    state_d = wb_we_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (!wb_cyc_i) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!peripheralBus_busy) begin
                    ack_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    rdata_d = ERROR_READ_DATA;
                    state_d = ST_FINISH;
                end else begin
                    we_d     = 1'b1;
                    cnt_incr = 1'b1;
                end
            end
            ST_READ: begin
                if (!wb_cyc_i) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!peripheralBus_busy) begin
                    state_d = ST_FINISH;
                    if (no_response) begin
                        err_d   = 1'b1;
                        rdata_d = ERROR_READ_DATA;
                    end else begin
                        ack_d   = 1'b1;
                        rdata_d = peripheralBus_dataRead;
                    end
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    rdata_d = ERROR_READ_DATA;
                    state_d = ST_FINISH;
                end else begin
                    oe_d     = 1'b1;
                    cnt_incr = 1'b1;
                end
            end
            ST_FINISH: begin
                // ack/err is visible this cycle; always return to IDLE
                cnt_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
        end
    end

    assign wb_ack_o                 = ack_q;
    assign wb_err_o                 = err_q;
    assign wb_data_o                = rdata_q;
    assign peripheralBus_we         = we_q;
    assign peripheralBus_oe         = oe_q;
    assign peripheralBus_address    = addr_q;
    assign peripheralBus_byteSelect = sel_q;
    assign peripheralBus_dataWrite  = wdata_q;

endmodule

// File: tb/tb_wb_peripheral_bridge.sv
// Directed bench for wb_peripheral_bridge (TIMEOUT_CYCLES=16, base 0x13).
module tb_wb_peripheral_bridge;

    logic        clk, rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_data_i;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] wb_data_o;
    logic        pb_we, pb_oe;
    logic [23:0] pb_addr;
    logic [3:0]  pb_sel;
    logic [31:0] pb_wdata, pb_rdata;
    logic        pb_req, pb_busy;

    int vectors = 0;
    int miscompares = 0;

    wb_peripheral_bridge #(.BASE_ADDRESS(8'h13), .TIMEOUT_CYCLES(16)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .wb_cyc_i                    (wb_cyc_i),
        .wb_stb_i                    (wb_stb_i),
        .wb_we_i                     (wb_we_i),
        .wb_sel_i                    (wb_sel_i),
        .wb_adr_i                    (wb_adr_i),
        .wb_data_i                   (wb_data_i),
        .wb_ack_o                    (wb_ack_o),
        .wb_err_o                    (wb_err_o),
        .wb_data_o                   (wb_data_o),
        .peripheralBus_we            (pb_we),
        .peripheralBus_oe            (pb_oe),
        .peripheralBus_address       (pb_addr),
        .peripheralBus_byteSelect    (pb_sel),
        .peripheralBus_dataWrite     (pb_wdata),
        .peripheralBus_dataRead      (pb_rdata),
        .peripheralBus_requestOutput (pb_req),
        .peripheralBus_busy          (pb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; samples are taken 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_sel_i = 0; wb_adr_i = 0; wb_data_i = 0;
    endtask

    task automatic start(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
        wb_adr_i = adr; wb_data_i = dat; wb_sel_i = sel;
    endtask

    task automatic test_reset();
        bus_idle();
        pb_rdata = 32'h5555_5555; pb_req = 0; pb_busy = 0;
        rst = 1;
        tick(); tick();
        vectors++;
        if ({wb_ack_o, wb_err_o, pb_we, pb_oe} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {wb_ack_o, wb_err_o, pb_we, pb_oe});
        end
        vectors++;
        if ({wb_data_o, pb_addr, pb_sel, pb_wdata} !== 92'd0) begin
            miscompares++;
            $display("FAIL reset_data: got data=%h addr=%h sel=%h wdata=%h want all 0",
                     wb_data_o, pb_addr, pb_sel, pb_wdata);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_write();
        start(1, 32'h1300_0104, 32'hDEAD_BEEF, 4'b0011);
        tick(); // acceptance edge
        vectors++;
        if ({pb_we, pb_oe, wb_ack_o, wb_err_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL write_strobe: got we/oe/ack/err=%b want 1000", {pb_we, pb_oe, wb_ack_o, wb_err_o});
        end
        vectors++;
        if ({pb_addr, pb_sel, pb_wdata} !== {24'h000104, 4'b0011, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL write_fields: got addr=%h sel=%b wdata=%h want 000104 0011 deadbeef",
                     pb_addr, pb_sel, pb_wdata);
        end
        tick();
        vectors++;
        if ({pb_we, pb_oe, wb_ack_o, wb_err_o} !== 4'b0010) begin
            miscompares++;
            $display("FAIL write_ack: got we/oe/ack/err=%b want 0010", {pb_we, pb_oe, wb_ack_o, wb_err_o});
        end
        bus_idle();
        tick();
        vectors++;
        if ({wb_ack_o, wb_err_o, pb_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL write_ack_once: got ack/err/we=%b want 000", {wb_ack_o, wb_err_o, pb_we});
        end
    endtask

    task automatic test_read();
        pb_rdata = 32'h0000_00A5; pb_req = 1;
        start(0, 32'h1300_0008, 32'h0, 4'hF);
        tick();
        vectors++;
        if ({pb_we, pb_oe, wb_ack_o, pb_addr} !== {3'b010, 24'h000008}) begin
            miscompares++;
            $display("FAIL read_strobe: got we/oe/ack=%b addr=%h want 010 000008",
                     {pb_we, pb_oe, wb_ack_o}, pb_addr);
        end
        tick();
        vectors++;
        if ({wb_ack_o, wb_err_o, pb_oe, wb_data_o} !== {3'b100, 32'h0000_00A5}) begin
            miscompares++;
            $display("FAIL read_ack: got ack/err/oe=%b data=%h want 100 000000a5",
                     {wb_ack_o, wb_err_o, pb_oe}, wb_data_o);
        end
        bus_idle();
        pb_rdata = 32'h0; pb_req = 0;
        tick();
        vectors++;
        if (wb_data_o !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL read_data_hold: got %h want 000000a5", wb_data_o);
        end
    endtask

    task automatic test_busy_read();
        int acks;
        acks = 0;
        pb_busy = 1; pb_rdata = 32'h1234_5678; pb_req = 1;
        start(0, 32'h1300_0010, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({pb_oe, wb_ack_o, wb_err_o} !== 3'b100) begin
                miscompares++;
                $display("FAIL busy_read_oe[%0d]: got oe/ack/err=%b want 100", i, {pb_oe, wb_ack_o, wb_err_o});
            end
            if (i == 3) pb_busy = 0;
            tick();
        end
        acks += int'(wb_ack_o);
        vectors++;
        if ({wb_ack_o, wb_err_o, pb_oe, wb_data_o} !== {3'b100, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL busy_read_ack: got ack/err/oe=%b data=%h want 100 12345678",
                     {wb_ack_o, wb_err_o, pb_oe}, wb_data_o);
        end
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            acks += int'(wb_ack_o);
        end
        vectors++;
        if (acks !== 1) begin
            miscompares++;
            $display("FAIL busy_read_ack_count: got %0d want 1", acks);
        end
        pb_req = 0; pb_rdata = 0;
    endtask

    task automatic test_timeout();
        int oe_cycles;
        int acks;
        oe_cycles = 0; acks = 0;
        pb_busy = 1;
        start(0, 32'h1300_0020, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 40 && pb_oe === 1'b1; i++) begin
            oe_cycles++;
            acks += int'(wb_ack_o);
            tick();
        end
        vectors++;
        if (oe_cycles !== 16) begin
            miscompares++;
            $display("FAIL timeout_oe_cycles: got %0d want 16", oe_cycles);
        end
        vectors++;
        if ({wb_err_o, wb_ack_o, wb_data_o} !== {2'b10, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL timeout_err: got err/ack=%b data=%h want 10 ffffffff",
                     {wb_err_o, wb_ack_o}, wb_data_o);
        end
        bus_idle();
        tick();
        acks += int'(wb_ack_o);
        vectors++;
        if ({wb_err_o, acks != 0, pb_oe} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_after: got err=%b acks=%0d oe=%b want 0 0 0", wb_err_o, acks, pb_oe);
        end
        pb_busy = 0;
        tick();
    endtask

    task automatic test_abort();
        pb_busy = 1;
        start(0, 32'h1300_0030, 32'h0, 4'hF);
        tick(); tick();
        vectors++;
        if (pb_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre_oe: got %b want 1", pb_oe);
        end
        bus_idle();
        tick();
        vectors++;
        if ({pb_oe, wb_ack_o, wb_err_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_drop: got oe/ack/err=%b want 000", {pb_oe, wb_ack_o, wb_err_o});
        end
        tick();
        vectors++;
        if ({pb_oe, wb_ack_o, wb_err_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_quiet: got oe/ack/err=%b want 000", {pb_oe, wb_ack_o, wb_err_o});
        end
        pb_busy = 0;
        start(1, 32'h1300_0000, 32'h5A5A_0001, 4'hF);
        tick();
        vectors++;
        if ({pb_we, pb_addr, pb_wdata} !== {1'b1, 24'h000000, 32'h5A5A_0001}) begin
            miscompares++;
            $display("FAIL abort_write_we: got we=%b addr=%h wdata=%h want 1 000000 5a5a0001",
                     pb_we, pb_addr, pb_wdata);
        end
        tick();
        vectors++;
        if ({wb_ack_o, wb_err_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_write_ack: got ack/err=%b want 10", {wb_ack_o, wb_err_o});
        end
        bus_idle();
        tick();
    endtask

    task automatic test_nomatch();
        int hits;
        hits = 0;
        start(1, 32'h1400_0000, 32'hCAFE_F00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({pb_we, pb_oe, wb_ack_o, wb_err_o} !== 4'b0000) hits++;
        end
        start(0, 32'h1400_0000, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({pb_we, pb_oe, wb_ack_o, wb_err_o} !== 4'b0000) hits++;
        end
        vectors++;
        if (hits !== 0) begin
            miscompares++;
            $display("FAIL nomatch_ignored: got %0d active cycles want 0", hits);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_unclaimed_read();
        pb_req = 0; pb_rdata = 32'h0;
        start(0, 32'h1300_0FFC, 32'h0, 4'hF);
        tick();
        vectors++;
        if ({pb_oe, pb_addr} !== {1'b1, 24'h000FFC}) begin
            miscompares++;
            $display("FAIL unclaimed_oe: got oe=%b addr=%h want 1 000ffc", pb_oe, pb_addr);
        end
        tick();
        vectors++;
`ifdef WB_PERIPHERAL_BRIDGE_NO_RESPONSE_ERROR_EN
        if ({wb_ack_o, wb_err_o, wb_data_o} !== {2'b01, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL unclaimed_resp: got ack/err=%b data=%h want 01 ffffffff",
                     {wb_ack_o, wb_err_o}, wb_data_o);
        end
`else
        if ({wb_ack_o, wb_err_o, wb_data_o} !== {2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL unclaimed_resp: got ack/err=%b data=%h want 10 00000000",
                     {wb_ack_o, wb_err_o}, wb_data_o);
        end
`endif
        bus_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_read();
        test_timeout();
        test_abort();
        test_nomatch();
        test_unclaimed_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
